mesh_job_ctrl: RTL and testbench

Sequencer in front of the mesh matrix-vector top (weight preload port, start pulse, x vector, flat result bus).
- Accepts a job request.
- Optionally streams a full ROWS×COLS weight set into the mesh preload port in row-major order.
- Latches the x vector, pulses start, waits a fixed compute latency, then captures the result into a valid/ready output buffer.
- Replaces the hand-timed preload/start/wait sequencing the mesh benches use today.

---
 rtl/mesh_pkg.sv | 27 ++
 rtl/mesh_preload_seq.sv | 64 ++++++
 rtl/mesh_job_ctrl.sv | 143 ++++++++++++++
 tb/tb_mesh_job_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh job sequencer, the mesh top and the mesh benches.
//   state_t      : sequencer state encoding (also exported on the debug 'state' port)
//   mesh_lat     : default compute latency from mesh_start to result capture
//   pack_addr    : preload address packing {row, col}
package mesh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_XWAIT   = 3'd2,
    ST_START   = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_RESULT  = 3'd5
  } state_t;

  // Fill and drain of the systolic mesh plus a small pipeline margin.
  function automatic int mesh_lat(input int rows, input int cols);
    return rows + cols + 5;
  endfunction

  // Callers slice the low (row_w + col_w) bits of the result.
  function automatic logic [31:0] pack_addr(input logic [15:0] row, input logic [15:0] col,
                                            input int col_w);
    return (32'(row) << col_w) | 32'(col);
  endfunction

endpackage

// File: rtl/mesh_preload_seq.sv
// Weight preload sequencer: walks {row, col} in row-major order (column fastest)
// for every accepted weight beat and registers the mesh preload port.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   load_en              high while the controller is in LOAD (acts as w_ready)
//   w_valid, w_data      incoming weight beat
//   preload_valid/addr/data  registered mesh preload port, one cycle after the beat
//   last_beat            combinational: the current beat is the final (ROWS-1, COLS-1) one
module mesh_preload_seq
  import mesh_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ROWS  = 40,
  parameter int COLS  = 40,
  parameter int ROW_W = 7,
  parameter int COL_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_en,
  input  logic                   w_valid,
  input  logic [DW-1:0]          w_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic [DW-1:0]          preload_data,
  output logic                   last_beat
);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             beat;
  logic             row_end;
  logic             col_end;

  assign beat      = load_en & w_valid;
  assign row_end   = (row == ROW_W'(ROWS - 1));
  assign col_end   = (col == COL_W'(COLS - 1));
  assign last_beat = beat & row_end & col_end;

  // The counters only move on accepted beats, so gap cycles can never skip
  // or repeat an address.  They return to {0,0} after the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row           <= '0;
      col           <= '0;
      preload_valid <= 1'b0;
      preload_addr  <= '0;
      preload_data  <= '0;
    end else begin
      preload_valid <= beat;
      if (beat) begin
        preload_data <= w_data;
        preload_addr <= (ROW_W+COL_W)'(pack_addr(16'(row), 16'(col), COL_W));
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mesh_job_ctrl.sv
// Job sequencer in front of the mesh matrix-vector top.
// Flow per job: optional full weight preload -> x vector latch -> one-cycle
// mesh_start -> fixed LAT-cycle wait -> result captured into a valid/ready buffer.
// Ports:
//   job_valid/job_reload/job_ready   job request (ready only in IDLE)
//   w_valid/w_data/w_ready           weight stream (ready only in LOAD)
//   x_valid/x_data/x_ready           x vector (ready only in XWAIT)
//   mesh_preload_*, mesh_start,
//   mesh_x_vector_flat               drive the mesh
//   mesh_result_flat                 mesh result bus
//   res_valid/res_data/res_ready     result buffer
//   state, weights_loaded, jobs_done debug/status
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; valid/ready inputs seen outside their owning state are ignored.
module mesh_job_ctrl
  import mesh_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ROWS    = 40,
  parameter int COLS    = 40,
  parameter int ROW_W   = 7,
  parameter int COL_W   = 7,
  parameter int ACC_W   = 16,
  parameter int CYCLE_W = 9,
  parameter int LAT     = mesh_lat(ROWS, COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  input  logic                   job_reload,
  output logic                   job_ready,
  input  logic                   w_valid,
  input  logic [DW-1:0]          w_data,
  output logic                   w_ready,
  input  logic                   x_valid,
  input  logic [COLS*DW-1:0]     x_data,
  output logic                   x_ready,
  output logic                   mesh_preload_valid,
  output logic [ROW_W+COL_W-1:0] mesh_preload_addr,
  output logic [DW-1:0]          mesh_preload_data,
  output logic                   mesh_start,
  output logic [COLS*DW-1:0]     mesh_x_vector_flat,
  input  logic [ROWS*ACC_W-1:0]  mesh_result_flat,
  output logic                   res_valid,
  output logic [ROWS*ACC_W-1:0]  res_data,
  input  logic                   res_ready,
  output logic [2:0]             state,
  output logic                   weights_loaded,
  output logic [15:0]            jobs_done
);

  state_t             state_q, state_d;
  logic [CYCLE_W-1:0] cnt;
  logic               last_beat;
  logic               capture;

  assign state = state_q;

  mesh_preload_seq #(
    .DW   (DW),
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_preload (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (w_ready),
    .w_valid      (w_valid),
    .w_data       (w_data),
    .preload_valid(mesh_preload_valid),
    .preload_addr (mesh_preload_addr),
    .preload_data (mesh_preload_data),
    .last_beat    (last_beat)
  );

  // The counter holds LAT-1 in the first COMPUTE cycle; capture happens on the
  // edge where it reaches 0, which is LAT cycles after the mesh_start cycle.
  assign capture = (state_q == ST_COMPUTE) && (cnt == CYCLE_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    job_ready  = 1'b0;
    w_ready    = 1'b0;
    x_ready    = 1'b0;
    mesh_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        // A job without reload is forced to load if no weight set exists yet.
        if (job_valid) state_d = (job_reload || !weights_loaded) ? ST_LOAD : ST_XWAIT;
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (last_beat) state_d = ST_XWAIT;
      end
      ST_XWAIT: begin
        x_ready = 1'b1;
        if (x_valid) state_d = ST_START;
      end
      ST_START: begin
        mesh_start = 1'b1;
        state_d    = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (capture) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt                <= '0;
      mesh_x_vector_flat <= '0;
      res_valid          <= 1'b0;
      res_data           <= '0;
      weights_loaded     <= 1'b0;
      jobs_done          <= '0;
    end else begin
      if (last_beat) weights_loaded <= 1'b1;
      if (x_ready && x_valid) mesh_x_vector_flat <= x_data;
      if (state_q == ST_START) cnt <= CYCLE_W'(LAT - 1);
      else if (state_q == ST_COMPUTE) cnt <= cnt - 1'b1;
      if (capture) begin
        res_data  <= mesh_result_flat;
        res_valid <= 1'b1;
      end else if (state_q == ST_RESULT && res_ready) begin
        res_valid <= 1'b0;
        jobs_done <= jobs_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mesh_job_ctrl.sv
module tb_mesh_job_ctrl;
  localparam int DW    = 8;
  localparam int ROWS  = 40;
  localparam int COLS  = 40;
  localparam int ROW_W = 7;
  localparam int COL_W = 7;
  localparam int ACC_W = 16;
  localparam int LAT   = 85;
  localparam int NW    = ROWS * COLS;
  localparam logic [15:0] EXP_ROW0  = 16'd10660;
  localparam logic [15:0] EXP_ROW1  = 16'd11480;
  localparam logic [15:0] EXP_ROW39 = 16'd42640;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   job_valid = 1'b0, job_reload = 1'b0, job_ready;
  logic                   w_valid = 1'b0, w_ready;
  logic [DW-1:0]          w_data = '0;
  logic                   x_valid = 1'b0, x_ready;
  logic [COLS*DW-1:0]     x_data = '0;
  logic                   mesh_preload_valid, mesh_start;
  logic [ROW_W+COL_W-1:0] mesh_preload_addr;
  logic [DW-1:0]          mesh_preload_data;
  logic [COLS*DW-1:0]     mesh_x_vector_flat;
  logic [ROWS*ACC_W-1:0]  mesh_result_flat;
  logic                   res_valid, res_ready = 1'b0;
  logic [ROWS*ACC_W-1:0]  res_data;
  logic [2:0]             state;
  logic                   weights_loaded;
  logic [15:0]            jobs_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mesh_job_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_reload(job_reload), .job_ready(job_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .mesh_preload_valid(mesh_preload_valid), .mesh_preload_addr(mesh_preload_addr),
    .mesh_preload_data(mesh_preload_data), .mesh_start(mesh_start),
    .mesh_x_vector_flat(mesh_x_vector_flat), .mesh_result_flat(mesh_result_flat),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .state(state), .weights_loaded(weights_loaded), .jobs_done(jobs_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural mesh: result[r] = sum_c w[r][c] * x[c], truncated to ACC_W.
  logic [NW*DW-1:0] w_flat = '0;

  function automatic logic [ROWS*ACC_W-1:0] mesh_model(input logic [NW*DW-1:0] wf,
                                                       input logic [COLS*DW-1:0] xf);
    logic [ROWS*ACC_W-1:0] res;
    int acc;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      acc = 0;
      for (int c = 0; c < COLS; c++)
        acc += int'($signed(wf[(r*COLS+c)*DW +: DW])) * int'($signed(xf[c*DW +: DW]));
      res[r*ACC_W +: ACC_W] = acc[ACC_W-1:0];
    end
    return res;
  endfunction

  assign mesh_result_flat = mesh_model(w_flat, mesh_x_vector_flat);

  // Preload monitor: addresses must walk row-major with no skips or repeats.
  int mon_r = 0, mon_c = 0, mon_beats = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_r = 0;
      mon_c = 0;
    end else if (mesh_preload_valid) begin
      check("preload_addr", 64'(mesh_preload_addr), 64'({ROW_W'(mon_r), COL_W'(mon_c)}));
      check("preload_data", 64'(mesh_preload_data), 64'(DW'(mon_r + mon_c)));
      w_flat[(mon_r*COLS+mon_c)*DW +: DW] = mesh_preload_data;
      mon_beats++;
      if (mon_c == COLS - 1) begin
        mon_c = 0;
        mon_r = (mon_r == ROWS - 1) ? 0 : mon_r + 1;
      end else begin
        mon_c++;
      end
    end
  end

  function automatic logic [COLS*DW-1:0] x_pattern();
    logic [COLS*DW-1:0] x;
    for (int c = 0; c < COLS; c++) x[c*DW +: DW] = DW'(COLS - c);
    return x;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_job_ready"}, 64'(job_ready), 64'd1);
    check({tag, "_w_ready"}, 64'(w_ready), 64'd0);
    check({tag, "_x_ready"}, 64'(x_ready), 64'd0);
    check({tag, "_pl_valid"}, 64'(mesh_preload_valid), 64'd0);
    check({tag, "_pl_addr"}, 64'(mesh_preload_addr), 64'd0);
    check({tag, "_pl_data"}, 64'(mesh_preload_data), 64'd0);
    check({tag, "_start"}, 64'(mesh_start), 64'd0);
    check({tag, "_xvec_zero"}, 64'(mesh_x_vector_flat == '0), 64'd1);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_zero"}, 64'(res_data == '0), 64'd1);
    check({tag, "_wloaded"}, 64'(weights_loaded), 64'd0);
    check({tag, "_jobs_done"}, 64'(jobs_done), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; job_valid = 1'b0; job_reload = 1'b0; w_valid = 1'b0; w_data = '0;
    x_valid = 1'b0; x_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("reset");
  endtask

  task automatic start_job(input bit reload, output int beats_before);
    @(negedge clk);
    check("job_ready_idle", 64'(job_ready), 64'd1);
    job_valid = 1'b1;
    job_reload = reload;
    @(posedge clk);
    beats_before = mon_beats;
    #1 job_valid = 1'b0;
    job_reload = 1'b0;
  endtask

  // Drives weight beats while w_ready; stops at x_ready or after 'limit' beats.
  task automatic feed_weights(input bit gap, input int limit, output int beats, output bit saw_wready);
    bit prev_acc = 1'b0;
    bit done = 1'b0;
    beats = 0;
    saw_wready = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      check("preload_valid_follows_beat", 64'(mesh_preload_valid), 64'(prev_acc));
      w_valid = 1'b0;
      prev_acc = 1'b0;
      if (w_ready) saw_wready = 1'b1;
      if (x_ready || beats == limit) begin
        done = 1'b1;
      end else if (w_ready && (!gap || cyc[0] == 1'b0)) begin
        w_valid = 1'b1;
        w_data = DW'(beats / COLS + beats % COLS);
        beats++;
        prev_acc = 1'b1;
      end
    end
    if (!done) check("feed_timeout", 64'd1, 64'd0);
  endtask

  task automatic finish_job(input bit hold, input logic [15:0] exp_jobs,
                            input int beats_before, input int exp_beats);
    int k_found = -1;
    bit extra_start = 1'b0;
    logic [ROWS*ACC_W-1:0] saved;
    x_valid = 1'b1;
    x_data = x_pattern();
    @(negedge clk);
    x_valid = 1'b0;
    check("start_pulse", 64'(mesh_start), 64'd1);
    check("x_latched", 64'(mesh_x_vector_flat == x_pattern()), 64'd1);
    for (int k = 1; k <= LAT + 4 && k_found < 0; k++) begin
      @(negedge clk);
      if (mesh_start) extra_start = 1'b1;
      if (res_valid) k_found = k;
    end
    check("res_latency", 64'(k_found), 64'(LAT));
    check("start_single_cycle", 64'(extra_start), 64'd0);
    check("res_row0", 64'(res_data[0 +: ACC_W]), 64'(EXP_ROW0));
    check("res_row1", 64'(res_data[ACC_W +: ACC_W]), 64'(EXP_ROW1));
    check("res_row39", 64'(res_data[39*ACC_W +: ACC_W]), 64'(EXP_ROW39));
    check("state_result", 64'(state), 64'd5);
    if (hold) begin
      saved = res_data;
      for (int i = 0; i < 10; i++) begin
        job_valid = 1'b1;
        @(negedge clk);
        check("hold_res_stable", 64'(res_data == saved), 64'd1);
        check("hold_res_valid", 64'(res_valid), 64'd1);
        check("hold_job_ready", 64'(job_ready), 64'd0);
        check("hold_state", 64'(state), 64'd5);
      end
      job_valid = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("release_res_valid", 64'(res_valid), 64'd0);
    check("release_state_idle", 64'(state), 64'd0);
    check("release_job_ready", 64'(job_ready), 64'd1);
    check("jobs_done", 64'(jobs_done), 64'(exp_jobs));
    check("preload_beats", 64'(mon_beats - beats_before), 64'(exp_beats));
  endtask

  typedef struct {
    bit          do_reset;
    bit          reload;
    bit          gap;
    int          exp_beats;
    bit          hold;
    logic [15:0] exp_jobs;
  } job_vec_t;

  job_vec_t vecs [4];

  initial begin
    int  bb, beats;
    bit  saw_wr, bad;
    // reload, back-to-back beats / reload with gaps / no reload + held result /
    // no reload right after reset (forced load)
    vecs[0] = '{do_reset: 1'b1, reload: 1'b1, gap: 1'b0, exp_beats: NW, hold: 1'b0, exp_jobs: 16'd1};
    vecs[1] = '{do_reset: 1'b0, reload: 1'b1, gap: 1'b1, exp_beats: NW, hold: 1'b0, exp_jobs: 16'd2};
    vecs[2] = '{do_reset: 1'b0, reload: 1'b0, gap: 1'b0, exp_beats: 0,  hold: 1'b1, exp_jobs: 16'd3};
    vecs[3] = '{do_reset: 1'b1, reload: 1'b0, gap: 1'b0, exp_beats: NW, hold: 1'b0, exp_jobs: 16'd1};

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_reset) apply_reset();
      start_job(vecs[i].reload, bb);
      feed_weights(vecs[i].gap, NW, beats, saw_wr);
      check("beats_driven", 64'(beats), 64'(vecs[i].exp_beats));
      check("w_ready_seen", 64'(saw_wr), 64'(vecs[i].exp_beats != 0));
      check("weights_loaded", 64'(weights_loaded), 64'd1);
      check("state_xwait", 64'(state), 64'd2);
      finish_job(vecs[i].hold, vecs[i].exp_jobs, bb, vecs[i].exp_beats);
    end

    // Reset in the middle of a preload: job abandoned, nothing issued afterwards.
    start_job(1'b1, bb);
    feed_weights(1'b0, 500, beats, saw_wr);
    check("midload_beats", 64'(beats), 64'd500);
    check("midload_pl_valid_before", 64'(mesh_preload_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midload");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w_valid = 1'b1;
    x_valid = 1'b1;
    res_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mesh_start || mesh_preload_valid) bad = 1'b1;
    end
    w_valid = 1'b0;
    x_valid = 1'b0;
    res_ready = 1'b0;
    check("after_reset_no_activity", 64'(bad), 64'd0);
    check("after_reset_idle", 64'(state), 64'd0);
    check("after_reset_wloaded", 64'(weights_loaded), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
